// File: rtl/vga_timing_output.sv
// VGA raster timing generator and pin driver with a pixel-clock divider, latency-aligned blanking,
// a bar test pattern and a frame-synchronous control register on the shared slave bus.
module vga_timing_output #(
  parameter int         PIX_DIV   = 4,
  parameter int         H_ACTIVE  = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_ACTIVE  = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter int         LAT       = 2,
  parameter logic [3:0] ADDR_CTRL = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  address,
  input  logic [3:0]  data,
  input  logic        valid,
  output logic        ack,
  output logic [3:0]  data_out,
  output logic        data_out_valid,
  input  logic [11:0] px_12bit_data,
  output logic [10:0] req_h,
  output logic [10:0] req_v,
  output logic        req_active,
  output logic        frame_start,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic [2:0] bar_index(input logic [10:0] h);
    bar_index = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(h) >= i * BAR_W) bar_index = 3'(i);
    end
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 12'hFFF;
      3'd1:    bar_colour = 12'hFF0;
      3'd2:    bar_colour = 12'h0FF;
      3'd3:    bar_colour = 12'h0F0;
      3'd4:    bar_colour = 12'hF0F;
      3'd5:    bar_colour = 12'hF00;
      3'd6:    bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      h_q, h_d, v_q, v_d;
  logic [3:0]       ctrl_q, ctrl_d, shd_q, shd_d, dout_q, dout_d;
  logic             ack_q, ack_d;
  logic [LAT-1:0]   act_sr_q, act_sr_d, hs_sr_q, hs_sr_d, vs_sr_q, vs_sr_d;
  logic [2:0]       bar_sr_q [LAT];
  logic [2:0]       bar_sr_d [LAT];
  logic [11:0]      rgb_q, rgb_d, pix_rgb;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             pix_tick, hs_raw, vs_raw, hit;

  always_comb begin
    pix_tick = (div_q == DIV_LAST);
    div_d    = pix_tick ? '0 : div_q + 1'b1;
    h_d      = h_q;
    v_d      = v_q;
    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  assign frame_start = pix_tick && (h_q == '0) && (v_q == '0);
  assign req_active  = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw      = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_raw      = (v_q >= VS_START) && (v_q < VS_END);

  // Timing qualifiers travel LAT ticks so they meet the pixel data fetched for the same coordinate.
  always_comb begin
    act_sr_d = act_sr_q;
    hs_sr_d  = hs_sr_q;
    vs_sr_d  = vs_sr_q;
    for (int i = 0; i < LAT; i++) bar_sr_d[i] = bar_sr_q[i];
    if (pix_tick) begin
      act_sr_d[0] = req_active;
      hs_sr_d[0]  = hs_raw;
      vs_sr_d[0]  = vs_raw;
      bar_sr_d[0] = bar_index(h_q);
      for (int i = 1; i < LAT; i++) begin
        act_sr_d[i] = act_sr_q[i-1];
        hs_sr_d[i]  = hs_sr_q[i-1];
        vs_sr_d[i]  = vs_sr_q[i-1];
        bar_sr_d[i] = bar_sr_q[i-1];
      end
    end
  end

  always_comb begin
    pix_rgb = 12'h000;
    if (act_sr_q[LAT-1] && shd_q[0]) begin
      pix_rgb = shd_q[1] ? bar_colour(bar_sr_q[LAT-1]) : px_12bit_data;
    end
    rgb_d = pix_tick ? pix_rgb : rgb_q;
    hs_d  = pix_tick ? ~(hs_sr_q[LAT-1] ^ shd_q[2]) : hs_q;
    vs_d  = pix_tick ? ~(vs_sr_q[LAT-1] ^ shd_q[3]) : vs_q;
  end

  // The shadow copy is only refreshed at frame start so pin behaviour never changes mid-frame.
  always_comb begin
    hit    = valid && (address == ADDR_CTRL);
    ctrl_d = hit ? data : ctrl_q;
    ack_d  = hit;
    dout_d = hit ? data : 4'h0;
    shd_d  = frame_start ? ctrl_q : shd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      ctrl_q   <= 4'b0001;
      shd_q    <= 4'b0001;
      dout_q   <= 4'h0;
      ack_q    <= 1'b0;
      act_sr_q <= '0;
      hs_sr_q  <= '0;
      vs_sr_q  <= '0;
      for (int i = 0; i < LAT; i++) bar_sr_q[i] <= 3'd0;
      rgb_q    <= 12'h000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      ctrl_q   <= ctrl_d;
      shd_q    <= shd_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      act_sr_q <= act_sr_d;
      hs_sr_q  <= hs_sr_d;
      vs_sr_q  <= vs_sr_d;
      for (int i = 0; i < LAT; i++) bar_sr_q[i] <= bar_sr_d[i];
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
    end
  end

  assign ack            = ack_q;
  assign data_out_valid = ack_q;
  assign data_out       = dout_q;
  assign req_h          = h_q;
  assign req_v          = v_q;
  assign vga_r          = rgb_q[11:8];
  assign vga_g          = rgb_q[7:4];
  assign vga_b          = rgb_q[3:0];
  assign vga_hs         = hs_q;
  assign vga_vs         = vs_q;

endmodule

// File: tb/tb_vga_timing_output.sv
// Self-checking bench for vga_timing_output on a shrunken raster (48x12 total, 32x6 active) so whole
// frames fit in a short run; a coordinate-level reference runs alongside directed bus and timing vectors.
module tb_vga_timing_output;

  localparam int HA = 32, HFP = 4, HSW = 8, HBP = 4, HT = HA + HFP + HSW + HBP;
  localparam int VA = 6,  VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
  localparam int FRAME_CLKS = HT * VT * 4;
  localparam int WAIT_LIMIT = 3 * FRAME_CLKS;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  address, data, data_out;
  logic        valid, ack, data_out_valid;
  logic [11:0] px_12bit_data;
  logic [10:0] req_h, req_v;
  logic        req_active, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  int checkCount = 0;
  int passCount  = 0;
  logic chkOn = 1'b0;

  vga_timing_output #(
    .PIX_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .LAT(2), .ADDR_CTRL(4'hA)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .data(data), .valid(valid),
    .ack(ack), .data_out(data_out), .data_out_valid(data_out_valid),
    .px_12bit_data(px_12bit_data), .req_h(req_h), .req_v(req_v),
    .req_active(req_active), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  always #5 clk = ~clk;

  // Source pixel pattern: never zero, distinct across neighbouring coordinates.
  function automatic logic [11:0] pxFunc(input logic [10:0] h, input logic [10:0] v);
    return {h[3:0], v[3:0] + 4'd1, h[5:4] ^ v[1:0], 2'b01};
  endfunction

  function automatic logic [11:0] barRef(input logic [10:0] h);
    case (int'(h) / (HA / 8))
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] refPixel(input logic ok, input logic [10:0] h, input logic [10:0] v,
                                           input logic [3:0] c);
    if (!ok || !c[0] || h >= HA || v >= VA) return 12'h000;
    if (c[1]) return barRef(h);
    return pxFunc(h, v);
  endfunction

  function automatic logic refSync(input logic ok, input logic [10:0] p, input int start, input int len,
                                   input logic inv);
    return ~((ok && int'(p) >= start && int'(p) < start + len) ^ inv);
  endfunction

  // Reference: own pixel divider and raster counters, a two-tick LAT source fed from req_h/req_v,
  // and the coordinate history that says which pixel the pins should be showing.
  int          tbDiv;
  logic [10:0] tbH, tbV, c1H, c1V, c2H, c2V, dispH, dispV;
  logic        c1Ok, c2Ok, dispOk;
  logic [11:0] stage1, stage2, expRgb;
  logic [3:0]  tbCtrl, tbShd, expDout;
  logic        expHs, expVs, expAck, expFs, expActive;

  assign px_12bit_data = stage2;
  assign expFs         = (tbDiv == 3) && (tbH == 0) && (tbV == 0);
  assign expActive     = (tbH < HA) && (tbV < VA);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tbDiv <= 0; tbH <= '0; tbV <= '0;
      c1H <= '0; c1V <= '0; c2H <= '0; c2V <= '0; dispH <= '0; dispV <= '0;
      c1Ok <= 1'b0; c2Ok <= 1'b0; dispOk <= 1'b0;
      stage1 <= '0; stage2 <= '0; expRgb <= '0;
      tbCtrl <= 4'b0001; tbShd <= 4'b0001; expDout <= 4'h0;
      expHs <= 1'b1; expVs <= 1'b1; expAck <= 1'b0;
    end else begin
      expAck  <= valid && (address == 4'hA);
      expDout <= (valid && address == 4'hA) ? data : 4'h0;
      if (valid && address == 4'hA) tbCtrl <= data;
      tbDiv <= (tbDiv == 3) ? 0 : tbDiv + 1;
      if (tbDiv == 3) begin
        stage1 <= pxFunc(req_h, req_v);
        stage2 <= stage1;
        c1H <= tbH; c1V <= tbV; c1Ok <= 1'b1;
        c2H <= c1H; c2V <= c1V; c2Ok <= c1Ok;
        dispH <= c2H; dispV <= c2V; dispOk <= c2Ok;
        expRgb <= refPixel(c2Ok, c2H, c2V, tbShd);
        expHs  <= refSync(c2Ok, c2H, HA + HFP, HSW, tbShd[2]);
        expVs  <= refSync(c2Ok, c2V, VA + VFP, VSW, tbShd[3]);
        if (tbH == 0 && tbV == 0) tbShd <= tbCtrl;
        if (tbH == 11'(HT - 1)) begin
          tbH <= '0;
          tbV <= (tbV == 11'(VT - 1)) ? '0 : tbV + 11'd1;
        end else begin
          tbH <= tbH + 11'd1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, got, want, $time);
  endtask

  // Continuous comparison against the reference, sampled on the falling edge.
  always @(negedge clk) begin
    if (chkOn) begin
      checkOutput("scan rgb", {vga_r, vga_g, vga_b}, expRgb);
      checkOutput("scan hs", 12'(vga_hs), 12'(expHs));
      checkOutput("scan vs", 12'(vga_vs), 12'(expVs));
      checkOutput("scan frame_start", 12'(frame_start), 12'(expFs));
      checkOutput("scan req_h", 12'(req_h), 12'(tbH));
      checkOutput("scan req_v", 12'(req_v), 12'(tbV));
      checkOutput("scan req_active", 12'(req_active), 12'(expActive));
      checkOutput("scan ack", 12'(ack), 12'(expAck));
      checkOutput("scan data_out_valid", 12'(data_out_valid), 12'(expAck));
      checkOutput("scan data_out", 12'(data_out), 12'(expDout));
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitCoord(input int h, input int v);
    int n = 0;
    while (!(dispOk && int'(dispH) == h && int'(dispV) == v) && n < WAIT_LIMIT) begin
      waitClk(1);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("waitCoord timeout", 12'd0, 12'd1);
  endtask

  task automatic waitFrameStart();
    int n = 0;
    while (!(tbDiv == 3 && tbH == 0 && tbV == 0) && n < WAIT_LIMIT) begin
      waitClk(1);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("frame start timeout", 12'd0, 12'd1);
    waitClk(1);
  endtask

  // One bus cycle; the response is registered, so it is visible right after the next edge.
  task automatic applyStimulus(input logic [3:0] addr, input logic [3:0] wdata);
    valid = 1'b1; address = addr; data = wdata;
    waitClk(1);
    valid = 1'b0; address = 4'h0; data = 4'h0;
  endtask

  task automatic countWindow(output int hsLow, output int vsLow, output int rgbNz);
    hsLow = 0; vsLow = 0; rgbNz = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      if (!vga_hs) hsLow++;
      if (!vga_vs) vsLow++;
      if ({vga_r, vga_g, vga_b} != 12'h000) rgbNz++;
      waitClk(1);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    checkOutput({tag, " hs"}, 12'(vga_hs), 12'd1);
    checkOutput({tag, " vs"}, 12'(vga_vs), 12'd1);
    checkOutput({tag, " ack"}, 12'(ack), 12'd0);
    checkOutput({tag, " data_out_valid"}, 12'(data_out_valid), 12'd0);
    checkOutput({tag, " data_out"}, 12'(data_out), 12'd0);
    checkOutput({tag, " frame_start"}, 12'(frame_start), 12'd0);
    checkOutput({tag, " req_h"}, 12'(req_h), 12'd0);
    checkOutput({tag, " req_v"}, 12'(req_v), 12'd0);
  endtask

  task automatic checkFirstTick(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, " frame_start"}, 12'(frame_start), (i == 3) ? 12'd1 : 12'd0);
      waitClk(1);
    end
    checkOutput({tag, " req_h after tick"}, 12'(req_h), 12'd1);
    checkOutput({tag, " req_v after tick"}, 12'(req_v), 12'd0);
  endtask

  initial begin
    int hsLow, vsLow, rgbNz, n;
    rst = 1'b1; valid = 1'b0; address = 4'h0; data = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;
    chkOn = 1'b1;
    checkFirstTick("release");

    // Default frame: sync edges, active pixels and blanking.
    waitCoord(35, 0);  checkOutput("hs before pulse", 12'(vga_hs), 12'd1);
    waitCoord(36, 0);  checkOutput("hs pulse start", 12'(vga_hs), 12'd0);
    waitCoord(43, 0);  checkOutput("hs pulse last", 12'(vga_hs), 12'd0);
    waitCoord(44, 0);  checkOutput("hs after pulse", 12'(vga_hs), 12'd1);
    waitCoord(5, 2);   checkOutput("active pixel", {vga_r, vga_g, vga_b}, pxFunc(11'd5, 11'd2));
    waitCoord(40, 2);  checkOutput("blank pixel", {vga_r, vga_g, vga_b}, 12'h000);
    waitCoord(0, 7);   checkOutput("vs before pulse", 12'(vga_vs), 12'd1);
    waitCoord(0, 8);   checkOutput("vs line 8", 12'(vga_vs), 12'd0);
    waitCoord(0, 9);   checkOutput("vs line 9", 12'(vga_vs), 12'd0);
    waitCoord(0, 10);  checkOutput("vs after pulse", 12'(vga_vs), 12'd1);

    waitFrameStart();
    waitClk(4);
    countWindow(hsLow, vsLow, rgbNz);
    checkOutput("frame hs low clks", 12'(hsLow), 12'd384);
    checkOutput("frame vs low clks", 12'(vsLow), 12'd384);
    checkOutput("frame nonzero rgb clks", 12'(rgbNz), 12'd768);

    // Mid-frame write of test pattern: bars only from the next frame.
    waitCoord(10, 3);
    applyStimulus(4'hA, 4'b0011);
    checkOutput("wr3 ack", 12'(ack), 12'd1);
    checkOutput("wr3 data_out_valid", 12'(data_out_valid), 12'd1);
    checkOutput("wr3 data_out", 12'(data_out), 12'd3);
    waitClk(1);
    checkOutput("wr3 ack drops", 12'(ack), 12'd0);
    checkOutput("wr3 data_out clears", 12'(data_out), 12'd0);
    waitCoord(4, 5);   checkOutput("no bars same frame", {vga_r, vga_g, vga_b}, pxFunc(11'd4, 11'd5));
    waitCoord(4, 1);   checkOutput("bar yellow", {vga_r, vga_g, vga_b}, 12'hFF0);
    waitCoord(8, 2);   checkOutput("bar cyan", {vga_r, vga_g, vga_b}, 12'h0FF);
    waitCoord(28, 2);  checkOutput("bar black", {vga_r, vga_g, vga_b}, 12'h000);

    // Both syncs inverted, pattern off.
    waitCoord(10, 3);
    applyStimulus(4'hA, 4'b1101);
    checkOutput("wr13 ack", 12'(ack), 12'd1);
    checkOutput("wr13 data_out", 12'(data_out), 12'd13);
    waitCoord(0, 1);
    checkOutput("inv hs idle", 12'(vga_hs), 12'd0);
    checkOutput("inv vs idle", 12'(vga_vs), 12'd0);
    checkOutput("inv rgb follows input", {vga_r, vga_g, vga_b}, pxFunc(11'd0, 11'd1));
    waitCoord(36, 1);  checkOutput("inv hs pulse", 12'(vga_hs), 12'd1);
    waitFrameStart();
    waitClk(4);
    countWindow(hsLow, vsLow, rgbNz);
    checkOutput("inv hs high clks", 12'(FRAME_CLKS - hsLow), 12'd384);
    checkOutput("inv vs high clks", 12'(FRAME_CLKS - vsLow), 12'd384);
    checkOutput("inv nonzero rgb clks", 12'(rgbNz), 12'd768);

    // Foreign address is ignored; writing 0 blanks the next frame but keeps syncs.
    applyStimulus(4'h5, 4'hF);
    checkOutput("addr5 ack", 12'(ack), 12'd0);
    checkOutput("addr5 data_out_valid", 12'(data_out_valid), 12'd0);
    checkOutput("addr5 data_out", 12'(data_out), 12'd0);
    applyStimulus(4'hA, 4'h0);
    checkOutput("wr0 ack", 12'(ack), 12'd1);
    checkOutput("wr0 data_out_valid", 12'(data_out_valid), 12'd1);
    checkOutput("wr0 data_out", 12'(data_out), 12'd0);
    waitFrameStart();
    waitClk(4);
    countWindow(hsLow, vsLow, rgbNz);
    checkOutput("off nonzero rgb clks", 12'(rgbNz), 12'd0);
    checkOutput("off hs low clks", 12'(hsLow), 12'd384);
    checkOutput("off vs low clks", 12'(vsLow), 12'd384);

    // Reset in the middle of a frame.
    n = 0;
    while (!(tbH == 20 && tbV == 3) && n < WAIT_LIMIT) begin
      waitClk(1);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("mid-frame reset timeout", 12'd0, 12'd1);
    rst = 1'b1;
    #1;
    checkResetState("async reset");
    waitClk(3);
    checkResetState("held reset");
    rst = 1'b0;
    checkFirstTick("re-release");
    waitCoord(5, 1);
    checkOutput("post-reset pixel", {vga_r, vga_g, vga_b}, pxFunc(11'd5, 11'd1));
    checkOutput("post-reset hs", 12'(vga_hs), 12'd1);

    chkOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
